// File: rtl/cnn_pkg.sv
// Shared CNN constants: default pixel width and convolution kernel size.
package cnn_pkg;
  localparam int BIT_DEPTH_DEF = 16;
  localparam int KSIZE         = 3;
  localparam int KTAPS         = KSIZE * KSIZE;
endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-stream / window bundle for conv_window_gen; coordinate signals exist
// only when CONV_WIN_COORD_EN is defined.
interface conv_window_gen_if
  import cnn_pkg::*;
#(
  parameter int bit_depth = BIT_DEPTH_DEF,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
);
  logic                 in_valid;
  logic                 in_sof;
  logic [bit_depth-1:0] in_pixel;
  logic                 win_valid;
  logic                 frame_done;
  logic [bit_depth-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
`ifdef CONV_WIN_COORD_EN
  logic [$clog2(IMG_H)-1:0] win_row;
  logic [$clog2(IMG_W)-1:0] win_col;
`endif

  modport master (
    output in_valid, in_sof, in_pixel,
    input  win_valid, frame_done,
    input  win0, win1, win2, win3, win4, win5, win6, win7, win8
`ifdef CONV_WIN_COORD_EN
    , input win_row, win_col
`endif
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output win_valid, frame_done,
    output win0, win1, win2, win3, win4, win5, win6, win7, win8
`ifdef CONV_WIN_COORD_EN
    , output win_row, win_col
`endif
  );
endinterface

// File: rtl/row_delay.sv
// Enable-gated shift line: dout is the sample accepted DEPTH enables earlier.
module row_delay #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  // Storage is deliberately not reset; contents are only observed after
  // two full rows have been written since the last frame start.
  logic [WIDTH-1:0] tap_reg [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (en) begin
      tap_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        tap_reg[i] <= tap_reg[i-1];
      end
    end
  end

  assign dout = tap_reg[DEPTH-1];
endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Optional macro CONV_WIN_COORD_EN adds win_row/win_col (window top-left).
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int bit_depth = BIT_DEPTH_DEF,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [bit_depth-1:0] in_pixel,
  output logic                 win_valid,
  output logic [bit_depth-1:0] win0,
  output logic [bit_depth-1:0] win1,
  output logic [bit_depth-1:0] win2,
  output logic [bit_depth-1:0] win3,
  output logic [bit_depth-1:0] win4,
  output logic [bit_depth-1:0] win5,
  output logic [bit_depth-1:0] win6,
  output logic [bit_depth-1:0] win7,
  output logic [bit_depth-1:0] win8,
  output logic                 frame_done
`ifdef CONV_WIN_COORD_EN
  ,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col
`endif
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0]     col_reg;
  logic [ROW_W-1:0]     row_reg;
  logic [COL_W-1:0]     cur_col;
  logic [ROW_W-1:0]     cur_row;
  logic                 last_col;
  logic                 last_row;
  logic                 win_ok;
  logic                 line_en;
  logic [bit_depth-1:0] line1_out;
  logic [bit_depth-1:0] line2_out;
  logic [bit_depth-1:0] col_in  [0:KSIZE-1];
  logic [bit_depth-1:0] win_reg [0:KTAPS-1];
  logic                 valid_reg;
  logic                 done_reg;

  // A start-of-frame pixel is position (0,0) regardless of the counters.
  assign cur_col  = in_sof ? '0 : col_reg;
  assign cur_row  = in_sof ? '0 : row_reg;
  assign last_col = (cur_col == COL_W'(IMG_W - 1));
  assign last_row = (cur_row == ROW_W'(IMG_H - 1));
  assign win_ok   = (cur_row >= ROW_W'(KSIZE - 1)) && (cur_col >= COL_W'(KSIZE - 1));
  assign line_en  = in_valid && !rst;

  row_delay #(.DEPTH(IMG_W), .WIDTH(bit_depth)) u_line1 (
    .clk  (clk),
    .en   (line_en),
    .din  (in_pixel),
    .dout (line1_out)
  );

  row_delay #(.DEPTH(IMG_W), .WIDTH(bit_depth)) u_line2 (
    .clk  (clk),
    .en   (line_en),
    .din  (line1_out),
    .dout (line2_out)
  );

  // New right-hand column, top to bottom: rows r-2, r-1, r.
  assign col_in[0] = line2_out;
  assign col_in[1] = line1_out;
  assign col_in[2] = in_pixel;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg   <= '0;
      row_reg   <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      for (int i = 0; i < KTAPS; i++) begin
        win_reg[i] <= '0;
      end
    end else begin
      valid_reg <= in_valid && win_ok;
      done_reg  <= in_valid && win_ok && last_row && last_col;
      if (in_valid) begin
        col_reg <= last_col ? '0 : cur_col + 1'b1;
        if (last_col) begin
          row_reg <= last_row ? '0 : cur_row + 1'b1;
        end else begin
          row_reg <= cur_row;
        end
        for (int k = 0; k < KSIZE; k++) begin
          for (int j = 0; j < KSIZE - 1; j++) begin
            win_reg[k*KSIZE + j] <= win_reg[k*KSIZE + j + 1];
          end
          win_reg[k*KSIZE + KSIZE - 1] <= col_in[k];
        end
      end
    end
  end

`ifdef CONV_WIN_COORD_EN
  logic [ROW_W-1:0] win_row_reg;
  logic [COL_W-1:0] win_col_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_row_reg <= '0;
      win_col_reg <= '0;
    end else if (in_valid && win_ok) begin
      win_row_reg <= cur_row - ROW_W'(KSIZE - 1);
      win_col_reg <= cur_col - COL_W'(KSIZE - 1);
    end
  end

  assign win_row = win_row_reg;
  assign win_col = win_col_reg;
`endif

  assign win_valid  = valid_reg;
  assign frame_done = done_reg;
  assign win0 = win_reg[0];
  assign win1 = win_reg[1];
  assign win2 = win_reg[2];
  assign win3 = win_reg[3];
  assign win4 = win_reg[4];
  assign win5 = win_reg[5];
  assign win6 = win_reg[6];
  assign win7 = win_reg[7];
  assign win8 = win_reg[8];
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x5 image, pixel = base + 5r + c.
// Coordinate outputs are also checked when CONV_WIN_COORD_EN is defined.
module tb_conv_window_gen;
  import cnn_pkg::*;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   nwin  = 0;

  always #5 clk = ~clk;

  conv_window_gen_if #(.bit_depth(BD), .IMG_W(W), .IMG_H(H)) bus ();

  conv_window_gen #(.bit_depth(BD), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (bus.in_valid),
    .in_sof     (bus.in_sof),
    .in_pixel   (bus.in_pixel),
    .win_valid  (bus.win_valid),
    .win0       (bus.win0),
    .win1       (bus.win1),
    .win2       (bus.win2),
    .win3       (bus.win3),
    .win4       (bus.win4),
    .win5       (bus.win5),
    .win6       (bus.win6),
    .win7       (bus.win7),
    .win8       (bus.win8),
    .frame_done (bus.frame_done)
`ifdef CONV_WIN_COORD_EN
    ,
    .win_row    (bus.win_row),
    .win_col    (bus.win_col)
`endif
  );

  logic [BD-1:0] w [0:8];
  assign w[0] = bus.win0;
  assign w[1] = bus.win1;
  assign w[2] = bus.win2;
  assign w[3] = bus.win3;
  assign w[4] = bus.win4;
  assign w[5] = bus.win5;
  assign w[6] = bus.win6;
  assign w[7] = bus.win7;
  assign w[8] = bus.win8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      $error("%s check did not match", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send pixel (r,c) of a frame, check the registered outputs, then idle
  // for gap cycles checking that the window holds.
  task automatic push(input logic sof, input int r, input int c, input int base, input int gap);
    logic exp_v;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_pixel = BD'(base + W*r + c);
    tick();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    exp_v = (r >= 2) && (c >= 2);
    chk($sformatf("win_valid(%0d,%0d)", r, c), 32'(bus.win_valid), 32'(exp_v));
    chk($sformatf("frame_done(%0d,%0d)", r, c), 32'(bus.frame_done),
        32'(exp_v && r == H-1 && c == W-1));
    if (exp_v) begin
      nwin++;
      for (int k = 0; k < 9; k++) begin
        chk($sformatf("win%0d(%0d,%0d)", k, r, c), 32'(w[k]),
            32'(base + W*(r - 2 + k/3) + (c - 2 + k%3)));
      end
`ifdef CONV_WIN_COORD_EN
      chk($sformatf("win_row(%0d,%0d)", r, c), 32'(bus.win_row), 32'(r - 2));
      chk($sformatf("win_col(%0d,%0d)", r, c), 32'(bus.win_col), 32'(c - 2));
`endif
    end
    for (int g = 0; g < gap; g++) begin
      tick();
      chk($sformatf("gap_valid(%0d,%0d)", r, c), 32'(bus.win_valid), 32'd0);
      chk($sformatf("gap_done(%0d,%0d)", r, c), 32'(bus.frame_done), 32'd0);
      if (exp_v) begin
        chk($sformatf("gap_win0(%0d,%0d)", r, c), 32'(w[0]), 32'(base + W*(r-2) + (c-2)));
        chk($sformatf("gap_win8(%0d,%0d)", r, c), 32'(w[8]), 32'(base + W*r + c));
      end
    end
  endtask

  task automatic frame(input int base, input int gap, input logic first_sof, input int npix);
    for (int p = 0; p < npix; p++) begin
      push(first_sof && (p == 0), p / W, p % W, base, gap);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pixel = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(bus.win_valid), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_win0", 32'(w[0]), 32'd0);
    chk("rst_win8", 32'(w[8]), 32'd0);
    rst = 1'b0;
    tick();
    $display("[TB] reset state checked");

    // Continuous frame: first window 0,1,2,5,6,7,10,11,12; last ends at 24
    nwin = 0;
    frame(0, 0, 1'b1, 25);
    chk("count_cont", nwin, 9);
    $display("[TB] continuous frame: %0d windows", nwin);

    // Same frame with two idle cycles after every pixel
    nwin = 0;
    frame(0, 2, 1'b1, 25);
    chk("count_gaps", nwin, 9);
    $display("[TB] gapped frame: %0d windows", nwin);

    // Back-to-back frames; second relies on natural counter wrap
    nwin = 0;
    frame(0, 0, 1'b1, 25);
    frame(100, 0, 1'b0, 25);
    chk("count_b2b", nwin, 18);
    $display("[TB] back-to-back frames: %0d windows", nwin);

    // Reset after pixel 17 with a pixel offered during reset (dropped)
    nwin = 0;
    frame(0, 0, 1'b1, 18);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pixel = BD'(999);
    tick();
    bus.in_valid = 1'b0;
    chk("midrst_valid", 32'(bus.win_valid), 32'd0);
    chk("midrst_done", 32'(bus.frame_done), 32'd0);
    chk("midrst_win8", 32'(w[8]), 32'd0);
    tick();
    chk("midrst_valid2", 32'(bus.win_valid), 32'd0);
    rst = 1'b0;
    frame(0, 0, 1'b0, 25);
    chk("count_rst", nwin, 4 + 9);
    $display("[TB] mid-frame reset: %0d windows", nwin);

    // Resync: in_sof at pixel 8 of a partial frame starts a new (0,0)
    nwin = 0;
    frame(200, 0, 1'b1, 8);
    frame(0, 0, 1'b1, 25);
    chk("count_sof", nwin, 9);
    $display("[TB] sof resync: %0d windows", nwin);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
